if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage for the five-stage MIPS core. Holds the PC, issues one outstanding request at a time on the instruction-SRAM handshake bus, and presents `{pc, instr, valid}` to the IF/ID pipeline register. Honours the hazard unit's stall, which is the inverse of that register's enable. Honours the redirect (branch/jump/exception) that flushes the IF/ID register, discarding any in-flight response.

## Interface
- `RESET_PC`, 32'hBFC0_0000, PC value loaded on reset.
- `clk` in 1: single clock; all state changes on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `stall` in 1: downstream not accepting (IF/ID enable low).
- `redirect_valid` in 1: flush and refetch from `redirect_pc`.
- `redirect_pc` in 32: redirect target.
- `inst_req` out 1: request valid.
- `inst_addr` out 32: request address (= PC).
- `inst_addr_ok` in 1: request accepted this cycle.
- `inst_data_ok` in 1: response valid this cycle.
- `inst_rdata` in 32: response data.
- `if_valid` out 1: `if_pc`/`if_instr` valid for IF/ID capture.
- `if_pc` out 32: PC of presented instruction.
- `if_instr` out 32: presented instruction.
- `if_adel` out 1: fetch address error flag.

## Operation
- States:
  - REQ: issuing.
  - WAIT: accepted, awaiting data.
  - HOLD: data captured, downstream stalled.
  - DROP: awaiting a response that must be discarded.
- Priority: redirect > data_ok > stall.
- REQ:
  - `inst_req`=1, `inst_addr`=pc.
  - `addr_ok` -> WAIT.
  - `redirect` -> pc<=redirect_pc. With `addr_ok` -> DROP, else stay REQ.
- WAIT:
  - `data_ok & !stall` -> `if_valid`=1, `if_instr`=`inst_rdata`; pc<=pc+4; -> REQ.
  - `data_ok & stall` -> `if_valid`=1, capture rdata into hold buffer; -> HOLD.
  - `redirect & data_ok` -> `if_valid`=0; pc<=redirect_pc; -> REQ.
  - `redirect & !data_ok` -> pc<=redirect_pc; -> DROP.
- HOLD:
  - `if_valid`=1, `if_instr`=buffer.
  - `!stall` -> pc<=pc+4, -> REQ.
  - `redirect` -> `if_valid`=0, pc<=redirect_pc, -> REQ.
- DROP:
  - `if_valid`=0.
  - `data_ok` -> REQ.
  - Further `redirect` updates pc and stays in DROP, unless `data_ok` arrives in the same cycle (-> REQ).
- `if_pc` = pc in every state. `if_valid` is forced 0 in any cycle with `redirect_valid`=1.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: state=REQ, pc=`RESET_PC`, `inst_req`=0 while `rst` is low, `if_valid`=0, `if_instr`=0, `if_adel`=0, hold buffer=0.
- First request is issued in the first clock edge-cycle after `rst` deasserts.
- Latency: `data_ok` to `if_valid` is 0 cycles (combinational pass-through). The next request is issued the cycle after IF/ID accepts.
- Peak throughput: one instruction per 2 cycles.
- `inst_req` stays high until `addr_ok`; `inst_addr` is stable while `inst_req`=1 unless `redirect` occurs.
- `rst` asserted mid-transaction returns the block to reset state immediately. The memory side must drop its outstanding response on the same reset.

## Configuration
- `IF_ADEL_CHECK_EN` defined:
  - In REQ with pc[1:0]!=0: `inst_req`=0, `if_valid`=1, `if_adel`=1, `if_instr`=32'h0.
  - pc holds until redirect; stall has no effect on this.
- `IF_ADEL_CHECK_EN` undefined:
  - `if_adel` is tied 0.
  - Misaligned pc is issued unchanged on `inst_addr`.

## Structure
- Package `if_pkg`: state enum `if_state_t` (REQ, WAIT, HOLD, DROP), `IF_RESET_PC` constant, `INSTR_NOP`=32'h0.
- One sub-module, `if_pc_next`: combinational next-PC mux (redirect_pc / pc+4 / pc).
- The FSM, hold buffer and PC register stay in the top module.

## Test plan
- Reset release, `addr_ok` and `data_ok` each 1 cycle after request, rdata=32'h2408_0001 -> `if_valid` pulse with pc=32'hBFC0_0000; next request at 32'hBFC0_0004.
- `stall`=1 for 3 cycles around `data_ok` -> state HOLD; `if_instr` stable 3 cycles; pc advances only after `stall` drops.
- `redirect_valid` with `redirect_pc`=32'h8000_0100 while in WAIT -> DROP; next response is discarded (`if_valid`=0); next `inst_addr`=32'h8000_0100.
- `redirect_valid` coincident with `data_ok` -> `if_valid`=0 that cycle; next request to redirect_pc; no DROP.
- `addr_ok` held low 5 cycles -> `inst_req`/`inst_addr` stable throughout; `rst` pulsed low mid-WAIT -> pc=`RESET_PC`, `if_valid`=0 immediately.
- With `IF_ADEL_CHECK_EN`, redirect to 32'h8000_0102 -> no `inst_req`; `if_valid`=1, `if_adel`=1 until the next redirect.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The optional fetch address-error check is enabled by defining IF_ADEL_CHECK_EN.
package if_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } if_state_t;

  typedef enum logic [1:0] {
    PC_KEEP  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_t;

  localparam logic [31:0] IF_RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] INSTR_NOP   = 32'h0000_0000;
  localparam logic [31:0] PC_STEP     = 32'd4;

  // Word fetches need the two low address bits clear.
  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return (pc_lo != 2'b00);
  endfunction

endpackage

// File: rtl/if_pc_next.sv
// Combinational next-PC selection: hold, sequential +4 (32-bit wrap) or redirect target.
module if_pc_next
  import if_pkg::*;
(
  input  pc_sel_t     sel,
  input  logic [31:0] pc,
  input  logic [31:0] redirect_pc,
  output logic [31:0] next_pc
);

  // Select the PC to be registered at the next edge
  always_comb begin
    next_pc = pc;
    case (sel)
      PC_KEEP:  next_pc = pc;
      PC_INC:   next_pc = pc + PC_STEP;
      PC_REDIR: next_pc = redirect_pc;
      default:  next_pc = pc;
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding SRAM handshake and IF/ID presentation.
// Defining IF_ADEL_CHECK_EN enables the misaligned-fetch address-error path.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_adel
);

  if_state_t   state_r;
  if_state_t   state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic [31:0] hold_buf_r;
  pc_sel_t     pc_sel_s;
  logic        hold_load_s;
  logic        adel_s;
  logic        valid_raw_s;

`ifdef IF_ADEL_CHECK_EN
  assign adel_s  = (state_r == REQ) && pc_misaligned(pc_r[1:0]);
  assign if_adel = adel_s & rst;
`else
  assign adel_s  = 1'b0;
  assign if_adel = 1'b0;
`endif

  assign inst_addr = pc_r;
  assign if_pc     = pc_r;

  if_pc_next u_pc_next (
    .sel         (pc_sel_s),
    .pc          (pc_r),
    .redirect_pc (redirect_pc),
    .next_pc     (pc_nxt_s)
  );

  // Next-state and PC-select decode; redirect outranks data_ok, which outranks stall
  always_comb begin
    state_nxt_s = state_r;
    pc_sel_s    = PC_KEEP;
    hold_load_s = 1'b0;
    case (state_r)
      REQ: begin
        if (redirect_valid) begin
          pc_sel_s = PC_REDIR;
          // A request already on the bus at the old PC still gets accepted; its data is junk.
          if (inst_addr_ok && !adel_s) begin
            state_nxt_s = DROP;
          end else begin
            state_nxt_s = REQ;
          end
        end else if (inst_addr_ok && !adel_s) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_sel_s = PC_REDIR;
          if (inst_data_ok) begin
            state_nxt_s = REQ;
          end else begin
            state_nxt_s = DROP;
          end
        end else if (inst_data_ok) begin
          if (stall) begin
            hold_load_s = 1'b1;
            state_nxt_s = HOLD;
          end else begin
            pc_sel_s    = PC_INC;
            state_nxt_s = REQ;
          end
        end else begin
          state_nxt_s = WAIT;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_sel_s    = PC_REDIR;
          state_nxt_s = REQ;
        end else if (!stall) begin
          pc_sel_s    = PC_INC;
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          pc_sel_s = PC_REDIR;
        end else begin
          pc_sel_s = PC_KEEP;
        end
        if (inst_data_ok) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s = REQ;
        pc_sel_s    = PC_KEEP;
      end
    endcase
  end

  // Bus request and IF/ID presentation; response data passes straight through
  always_comb begin
    inst_req    = 1'b0;
    valid_raw_s = 1'b0;
    if_instr    = INSTR_NOP;
    case (state_r)
      REQ: begin
        if (adel_s) begin
          valid_raw_s = 1'b1;
        end else begin
          inst_req = rst;
        end
      end
      WAIT: begin
        if (inst_data_ok) begin
          valid_raw_s = 1'b1;
          if_instr    = inst_rdata;
        end else begin
          valid_raw_s = 1'b0;
        end
      end
      HOLD: begin
        valid_raw_s = 1'b1;
        if_instr    = hold_buf_r;
      end
      DROP: begin
        valid_raw_s = 1'b0;
      end
      default: begin
        valid_raw_s = 1'b0;
      end
    endcase
    if_valid = valid_raw_s & rst & ~redirect_valid;
  end

  // State, PC and hold-buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= REQ;
      pc_r       <= RESET_PC;
      hold_buf_r <= INSTR_NOP;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      if (hold_load_s) begin
        hold_buf_r <= inst_rdata;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage; the misaligned-fetch scenario runs when IF_ADEL_CHECK_EN is defined.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_adel;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb_q[$];

  if_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_adel        (if_adel)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // IF/ID capture point: any instruction accepted downstream must match the scoreboard head
  always @(negedge clk) begin
    if (rst && if_valid && !stall && !redirect_valid && !if_adel) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_valid", if_pc, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check_eq("sb_pc", if_pc, e[63:32]);
        check_eq("sb_instr", if_instr, e[31:0]);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] exp_addr);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_req) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("req_seen", {31'd0, found}, 32'd1);
    if (found) check_eq("req_addr", inst_addr, exp_addr);
  endtask

  // Issue and accept a request, holding addr_ok low for alat cycles first; returns in WAIT.
  task automatic issue_accept(input logic [31:0] addr, input int alat);
    wait_req(addr);
    for (int i = 0; i < alat; i++) begin
      step();
      @(negedge clk);
      check_eq("req_hold", {31'd0, inst_req}, 32'd1);
      check_eq("addr_hold", inst_addr, addr);
    end
    step();
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input int alat, input int dlat,
                          input int nstall, input logic [31:0] rdata);
    issue_accept(addr, alat);
    for (int i = 1; i < dlat; i++) step();
    inst_data_ok = 1'b1;
    inst_rdata   = rdata;
    stall        = (nstall > 0);
    sb_q.push_back({addr, rdata});
    @(negedge clk);
    check_eq("data_valid", {31'd0, if_valid}, 32'd1);
    check_eq("data_instr", if_instr, rdata);
    step();
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    if (nstall > 0) begin
      for (int i = 1; i < nstall; i++) begin
        @(negedge clk);
        check_eq("hold_valid", {31'd0, if_valid}, 32'd1);
        check_eq("hold_instr", if_instr, rdata);
        check_eq("hold_pc", if_pc, addr);
        check_eq("hold_noreq", {31'd0, inst_req}, 32'd0);
        step();
      end
      stall = 1'b0;
      @(negedge clk);
      check_eq("unstall_instr", if_instr, rdata);
      step();
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_req", {31'd0, inst_req}, 32'd0);
    check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_adel", {31'd0, if_adel}, 32'd0);
    check_eq("rst_instr", if_instr, 32'h0);
    check_eq("rst_pc", if_pc, 32'hBFC0_0000);
    step();
    rst = 1'b1;

    // Basic fetch, then sequential fetch with a 3-cycle stall around data_ok
    do_fetch(32'hBFC0_0000, 0, 1, 0, 32'h2408_0001);
    do_fetch(32'hBFC0_0004, 0, 1, 3, instr_of(32'hBFC0_0004));
    do_fetch(32'hBFC0_0008, 0, 2, 1, instr_of(32'hBFC0_0008));

    // Redirect while in WAIT: in-flight response discarded
    issue_accept(32'hBFC0_000C, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    @(negedge clk);
    check_eq("redir_wait_valid", {31'd0, if_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("drop_pc", if_pc, 32'h8000_0100);
    check_eq("drop_noreq", {31'd0, inst_req}, 32'd0);
    step();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("drop_valid", {31'd0, if_valid}, 32'd0);
    step();
    inst_data_ok = 1'b0;
    do_fetch(32'h8000_0100, 0, 1, 0, instr_of(32'h8000_0100));

    // Redirect coincident with data_ok: no DROP, immediate refetch
    issue_accept(32'h8000_0104, 0);
    inst_data_ok   = 1'b1;
    inst_rdata     = 32'h1111_2222;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    @(negedge clk);
    check_eq("redir_data_valid", {31'd0, if_valid}, 32'd0);
    step();
    inst_data_ok   = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("no_drop_req", {31'd0, inst_req}, 32'd1);
    check_eq("no_drop_addr", inst_addr, 32'h8000_0200);
    do_fetch(32'h8000_0200, 5, 1, 0, instr_of(32'h8000_0200));

    // Redirect in REQ to the top word, then PC wraps to zero
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    do_fetch(32'hFFFF_FFFC, 0, 1, 0, instr_of(32'hFFFF_FFFC));
    do_fetch(32'h0000_0000, 0, 1, 0, instr_of(32'h0000_0000));

    // Reset pulsed mid-WAIT
    issue_accept(32'h0000_0004, 0);
    rst = 1'b0;
    #1;
    check_eq("midrst_pc", if_pc, 32'hBFC0_0000);
    check_eq("midrst_valid", {31'd0, if_valid}, 32'd0);
    check_eq("midrst_req", {31'd0, inst_req}, 32'd0);
    step();
    rst = 1'b1;
    do_fetch(32'hBFC0_0000, 0, 1, 0, instr_of(32'hBFC0_0000));

`ifdef IF_ADEL_CHECK_EN
    // Misaligned redirect raises an address error and holds until redirected
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stall = (i == 1);
      @(negedge clk);
      check_eq("adel_noreq", {31'd0, inst_req}, 32'd0);
      check_eq("adel_valid", {31'd0, if_valid}, 32'd1);
      check_eq("adel_flag", {31'd0, if_adel}, 32'd1);
      check_eq("adel_instr", if_instr, 32'h0);
      check_eq("adel_pc", if_pc, 32'h8000_0102);
      step();
    end
    stall          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    @(negedge clk);
    check_eq("adel_redir_valid", {31'd0, if_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    do_fetch(32'h8000_0300, 0, 1, 0, instr_of(32'h8000_0300));
    check_eq("adel_clear", {31'd0, if_adel}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    check_eq("sb_left", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
